// File: rtl/ps2_pkg.sv
// Shared PS/2 link constants and transmitter state encoding.
// The host receiver imports the same frame constants.
package ps2_pkg;

    localparam logic        PS2_START      = 1'b0;
    localparam logic        PS2_STOP       = 1'b1;
    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } ps2_tx_state_t;

    // Bit k of the result is the k-th bit on the wire (start first, stop last).
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
        return {PS2_STOP, ~^b, b, PS2_START};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// 8x8 scan-code FIFO feeding the PS/2 transmitter.
// A push while full is accepted only if a pop happens in the same cycle.
module ps2_tx_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    logic [7:0] mem [8];
    logic [2:0] w_ptr;
    logic [2:0] r_ptr;
    logic       do_pop;
    logic       do_push;

    assign full     = (count == 4'd8);
    assign empty    = (count == 4'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[r_ptr];

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[w_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                w_ptr <= w_ptr + 3'd1;
            end
            if (do_pop) begin
                r_ptr <= r_ptr + 3'd1;
            end
            count <= count + {3'b000, do_push} - {3'b000, do_pop};
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard transmitter: FIFO-buffered scan codes sent as
// 11-bit frames on ps2_clk/ps2_data, with a fixed idle gap after each frame.
module ps2_keyboard_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HALF = 4,
    parameter int unsigned GAP      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       inhibit,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       sent,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int unsigned HW = $clog2(CLK_HALF) + 1;
    localparam int unsigned GW = $clog2(GAP) + 1;
    localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_HALF - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

    ps2_tx_state_t             state;
    logic [HW-1:0]             half_cnt;
    logic [GW-1:0]             gap_cnt;
    logic [3:0]                bit_idx;
    logic [PS2_FRAME_BITS-1:0] frame;

    logic [7:0] fifo_rd_data;
    logic [3:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_has_data;
    logic       pop;

    assign fifo_has_data = !fifo_empty && (fifo_count != '0);
    assign pop           = (state == ST_IDLE) && fifo_has_data && !inhibit;

    ps2_tx_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count),
        .full      (full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    // Outputs are registered from the state being processed, so each phase
    // appears on the pins one edge after the state is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            half_cnt <= '0;
            gap_cnt  <= '0;
            bit_idx  <= '0;
            frame    <= '1;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
            sent     <= 1'b0;
        end else begin
            sent <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    busy     <= 1'b0;
                    if (pop) begin
                        frame    <= ps2_frame(fifo_rd_data);
                        bit_idx  <= '0;
                        half_cnt <= HALF_LOAD;
                        state    <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= frame[bit_idx];
                    busy     <= 1'b1;
                    if (half_cnt == '0) begin
                        half_cnt <= HALF_LOAD;
                        state    <= ST_LOW;
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                ST_LOW: begin
                    ps2_clk <= 1'b0;
                    busy    <= 1'b1;
                    if (half_cnt == '0) begin
                        half_cnt <= HALF_LOAD;
                        if (bit_idx == LAST_BIT) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            state   <= ST_HIGH;
                        end
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    busy     <= 1'b1;
                    sent     <= (gap_cnt == GAP_LOAD);
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Self-checking bench for ps2_keyboard_tx: table-driven frame vectors plus
// directed timing, overflow, inhibit, reset and write/pop corner cases.
module tb_ps2_keyboard_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       inhibit;
    logic       full;
    logic       overflow;
    logic       busy;
    logic       sent;
    logic       ps2_clk;
    logic       ps2_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [10:0] frames[$];
    int          starts[$];
    int          falls    = 0;
    int          sent_cnt = 0;
    int          nbits    = 0;
    int          first_fall;
    logic [10:0] shreg;
    logic        prev_clk = 1'b1;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;
    vec_t vecs[6];

    ps2_keyboard_tx #(.CLK_HALF(4), .GAP(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .inhibit  (inhibit),
        .full     (full),
        .overflow (overflow),
        .busy     (busy),
        .sent     (sent),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame capture: ps2_data sampled at each falling ps2_clk edge.
    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
        end else if (prev_clk && !ps2_clk) begin
            falls++;
            if (nbits == 0) first_fall = cyc;
            shreg[nbits] = ps2_data;
            nbits++;
            if (nbits == 11) begin
                frames.push_back(shreg);
                starts.push_back(first_fall);
                nbits = 0;
            end
        end
        prev_clk = ps2_clk;
        if (sent) sent_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] model_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic goto(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic clear_mon();
        frames.delete();
        starts.delete();
    endtask

    initial begin
        int w;
        int f0;
        int s0;

        vecs[0] = '{8'h1C, 11'b10000111000};
        vecs[1] = '{8'hF0, 11'b11111100000};
        vecs[2] = '{8'h00, 11'b11000000000};
        vecs[3] = '{8'hFF, 11'b11111111110};
        vecs[4] = '{8'hA5, 11'b11101001010};
        vecs[5] = '{8'h80, 11'b10100000000};

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; inhibit = 1'b0;
        repeat (3) step();
        check("rst_ps2_clk", ps2_clk, 1);
        check("rst_ps2_data", ps2_data, 1);
        check("rst_busy", busy, 0);
        check("rst_sent", sent, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        step();

        // Single byte: exact edge timing relative to the write edge.
        clear_mon();
        s0 = sent_cnt;
        write_byte(8'h1C);
        w = cyc;
        goto(w + 1);
        check("single_idle_data_e1", ps2_data, 1);
        check("single_busy_e1", busy, 0);
        goto(w + 2);
        check("single_start_bit_e2", ps2_data, 0);
        check("single_clk_high_e2", ps2_clk, 1);
        check("single_busy_e2", busy, 1);
        goto(w + 89);
        check("single_sent_e89", sent, 0);
        goto(w + 90);
        check("single_sent_e90", sent, 1);
        goto(w + 91);
        check("single_sent_e91", sent, 0);
        goto(w + 97);
        check("single_busy_e97", busy, 1);
        goto(w + 98);
        check("single_busy_e98", busy, 0);
        check("single_nframes", frames.size(), 1);
        if (frames.size() >= 1) begin
            check("single_frame_bits", frames[0], 11'b10000111000);
            check("single_first_fall", starts[0], w + 6);
        end
        check("single_sent_count", sent_cnt - s0, 1);

        // Table-driven frame contents and start latency.
        foreach (vecs[i]) begin
            clear_mon();
            write_byte(vecs[i].data);
            w = cyc;
            wait_frames(1, 300);
            check($sformatf("vec%0d_nframes", i), frames.size(), 1);
            if (frames.size() >= 1) begin
                check($sformatf("vec%0d_frame", i), frames[0], vecs[i].frame);
                check($sformatf("vec%0d_first_fall", i), starts[0], w + 6);
            end
            wait_idle(200);
            check($sformatf("vec%0d_idle", i), busy, 0);
        end

        // Back-to-back frames: start bits 97 cycles apart.
        clear_mon();
        s0 = sent_cnt;
        write_byte(8'h1C);
        w = cyc;
        write_byte(8'hF0);
        write_byte(8'h1C);
        wait_frames(3, 600);
        check("b2b_nframes", frames.size(), 3);
        if (frames.size() >= 3) begin
            check("b2b_frame0", frames[0], 11'b10000111000);
            check("b2b_frame1", frames[1], 11'b11111100000);
            check("b2b_frame2", frames[2], 11'b10000111000);
            check("b2b_start0", starts[0], w + 6);
            check("b2b_start1", starts[1], w + 6 + 97);
            check("b2b_start2", starts[2], w + 6 + 194);
        end
        wait_idle(200);
        check("b2b_sent_count", sent_cnt - s0, 3);

        // Full / overflow under inhibit, then drain.
        clear_mon();
        inhibit = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            write_byte(8'(i));
            if (i == 7) check("ovf_full_after7", full, 0);
            if (i == 8) begin
                check("ovf_full_after8", full, 1);
                check("ovf_overflow_after8", overflow, 0);
            end
            if (i == 9) check("ovf_overflow_after9", overflow, 1);
        end
        repeat (20) step();
        check("ovf_inhibited_nframes", frames.size(), 0);
        check("ovf_inhibited_busy", busy, 0);
        inhibit = 1'b0;
        wait_frames(8, 8 * 97 + 100);
        repeat (200) step();
        check("ovf_drain_nframes", frames.size(), 8);
        for (int i = 0; i < 8 && i < frames.size(); i++) begin
            check($sformatf("ovf_drain_frame%0d", i), frames[i], model_frame(8'(i + 1)));
        end
        check("ovf_sticky", overflow, 1);

        // Inhibit raised during bit 4 of frame 1.
        clear_mon();
        write_byte(8'hA5);
        write_byte(8'h3C);
        f0 = falls;
        for (int k = 0; k < 400 && falls < f0 + 4; k++) step();
        inhibit = 1'b1;
        wait_frames(1, 300);
        wait_idle(200);
        repeat (50) step();
        check("inh_nframes", frames.size(), 1);
        check("inh_idle_clk", ps2_clk, 1);
        check("inh_idle_data", ps2_data, 1);
        check("inh_idle_busy", busy, 0);
        if (frames.size() >= 1) check("inh_frame0", frames[0], model_frame(8'hA5));
        inhibit = 1'b0;
        w = cyc;
        wait_frames(2, 300);
        check("inh_resume_nframes", frames.size(), 2);
        if (frames.size() >= 2) begin
            check("inh_resume_frame", frames[1], model_frame(8'h3C));
            check("inh_resume_first_fall", starts[1], w + 6);
        end
        wait_idle(200);

        // Reset during bit 5 with bytes queued; overflow is still set here.
        clear_mon();
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        f0 = falls;
        for (int k = 0; k < 400 && falls < f0 + 5; k++) step();
        rst = 1'b1;
        step();
        check("rstmid_ps2_clk", ps2_clk, 1);
        check("rstmid_ps2_data", ps2_data, 1);
        check("rstmid_busy", busy, 0);
        check("rstmid_full", full, 0);
        check("rstmid_overflow", overflow, 0);
        rst = 1'b0;
        f0 = falls;
        repeat (200) step();
        check("rstmid_no_edges", falls - f0, 0);
        check("rstmid_no_frames", frames.size(), 0);

        // Write in the IDLE pop cycle while full.
        clear_mon();
        inhibit = 1'b1;
        for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i));
        check("sim_full_before", full, 1);
        inhibit = 1'b0;
        write_byte(8'h18);
        check("sim_full_after", full, 1);
        check("sim_overflow_after", overflow, 0);
        wait_frames(9, 9 * 97 + 200);
        check("sim_nframes", frames.size(), 9);
        for (int i = 0; i < 9 && i < frames.size(); i++) begin
            check($sformatf("sim_frame%0d", i), frames[i], model_frame(8'h10 + 8'(i)));
        end
        wait_idle(200);
        check("sim_overflow_end", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
